// File: rtl/trdb_pkg.sv
// Shared constants and types for the trace packet reader path.
package trdb_pkg;

   localparam int PACKET_LEN  = 128;
   localparam int LEN_FIELD   = 7;
   localparam int MSGTYPE_LEN = 2;
   localparam int PKT_LEN_W   = 8;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } trdb_deser_state_e;

   typedef logic [PACKET_LEN-1:0] trdb_packet_t;

   // Payload length must cover the message type and fit the packet register.
   function automatic logic legal_payload_len(input logic [LEN_FIELD-1:0] l);
      return (int'(l) >= MSGTYPE_LEN) && (int'(l) <= PACKET_LEN - LEN_FIELD);
   endfunction

endpackage

// File: rtl/trdb_packet_deserializer.sv
// Reassembles word-aligned trace packets into a 128-bit register using the header length field.
// Optional idle timeout in COLLECT: define TRDB_DESER_TIMEOUT_EN.
module trdb_packet_deserializer
   import trdb_pkg::*;
#(
   parameter int WORD_LEN       = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [WORD_LEN-1:0]    word_i,
   input  logic                   word_valid_i,
   output logic                   word_ready_o,
   output trdb_packet_t           packet_o,
   output logic [PKT_LEN_W-1:0]   packet_len_o,
   output logic [MSGTYPE_LEN-1:0] msgtype_o,
   output logic                   packet_valid_o,
   input  logic                   packet_ready_i,
   output logic                   err_o
);

   localparam int WORDS = PACKET_LEN / WORD_LEN;
   localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int IDX_W = $clog2(PACKET_LEN);

   if ((PACKET_LEN % WORD_LEN) != 0) begin : g_bad_word_len
      $error("PACKET_LEN must be a multiple of WORD_LEN");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   trdb_deser_state_e    state;
   logic [CNT_W-1:0]     remaining;
   logic [CNT_W-1:0]     slice_idx;

   logic                 word_fire;
   logic [LEN_FIELD-1:0] hdr_l;
   logic                 hdr_legal;
   logic [PKT_LEN_W-1:0] hdr_total;
   logic [PKT_LEN_W-1:0] cur_total;
   logic [CNT_W-1:0]     hdr_last;
   logic [CNT_W-1:0]     wr_idx;
   logic [IDX_W-1:0]     wr_base;
   logic [WORD_LEN-1:0]  wr_word;

`ifdef TRDB_DESER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0]      idle_cnt;
`endif

   // NOTE: every signal driven here gets a value on every path, so no latch can be inferred.
   always_comb begin
      word_ready_o = !packet_valid_o || packet_ready_i;
      word_fire    = word_valid_i && word_ready_o;

      hdr_l     = word_i[LEN_FIELD-1:0];
      hdr_legal = legal_payload_len(hdr_l);
      hdr_total = PKT_LEN_W'(hdr_l) + PKT_LEN_W'(LEN_FIELD);
      // Index of the last word, i.e. ceil(T / WORD_LEN) - 1.
      hdr_last  = CNT_W'((int'(hdr_total) - 1) / WORD_LEN);

      wr_idx    = (state == IDLE) ? '0 : slice_idx;
      cur_total = (state == IDLE) ? hdr_total : packet_len_o;
      wr_base   = IDX_W'(int'(wr_idx) * WORD_LEN);

      // Bits at or beyond the packet's total length never reach packet_o.
      wr_word = '0;
      for (int b = 0; b < WORD_LEN; b++) begin
         wr_word[b] = word_i[b] && ((int'(wr_idx) * WORD_LEN + b) < int'(cur_total));
      end
   end

   // NOTE: synchronous reset lives inside the clocked block; all state updates use <= so
   // every read in this block sees the pre-edge value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         remaining      <= '0;
         slice_idx      <= '0;
         packet_o       <= '0;
         packet_len_o   <= '0;
         msgtype_o      <= '0;
         packet_valid_o <= 1'b0;
         err_o          <= 1'b0;
`ifdef TRDB_DESER_TIMEOUT_EN
         idle_cnt       <= '0;
`endif
      end else begin
         err_o <= 1'b0;
         if (packet_valid_o && packet_ready_i) begin
            packet_valid_o <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (word_fire) begin
                  if (hdr_legal) begin
                     packet_o     <= trdb_packet_t'(wr_word);
                     packet_len_o <= hdr_total;
                     msgtype_o    <= word_i[LEN_FIELD +: MSGTYPE_LEN];
                     remaining    <= hdr_last;
                     slice_idx    <= CNT_W'(1);
`ifdef TRDB_DESER_TIMEOUT_EN
                     idle_cnt     <= '0;
`endif
                     if (hdr_last == '0) begin
                        packet_valid_o <= 1'b1;
                     end else begin
                        state <= COLLECT;
                     end
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end

            COLLECT: begin
               if (word_fire) begin
                  packet_o[wr_base +: WORD_LEN] <= wr_word;
                  remaining <= remaining - CNT_W'(1);
                  slice_idx <= slice_idx + CNT_W'(1);
`ifdef TRDB_DESER_TIMEOUT_EN
                  idle_cnt  <= '0;
`endif
                  if (remaining == CNT_W'(1)) begin
                     packet_valid_o <= 1'b1;
                     state          <= IDLE;
                  end
               end
`ifdef TRDB_DESER_TIMEOUT_EN
               else if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  // Stalled stream: drop the partial packet and resync on the next header.
                  packet_o     <= '0;
                  packet_len_o <= '0;
                  msgtype_o    <= '0;
                  idle_cnt     <= '0;
                  err_o        <= 1'b1;
                  state        <= IDLE;
               end else begin
                  idle_cnt <= idle_cnt + TO_W'(1);
               end
`endif
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trdb_packet_deserializer.sv
// Bench for trdb_packet_deserializer: vector table plus hand-written corner sequences, scoreboard-checked.
module tb_trdb_packet_deserializer;
   import trdb_pkg::*;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [31:0]   word_i;
   logic          word_valid_i;
   logic          word_ready_o;
   trdb_packet_t  packet_o;
   logic [7:0]    packet_len_o;
   logic [1:0]    msgtype_o;
   logic          packet_valid_o;
   logic          packet_ready_i;
   logic          err_o;

   trdb_packet_deserializer #(.WORD_LEN(32), .TIMEOUT_CYCLES(8)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .word_i         (word_i),
      .word_valid_i   (word_valid_i),
      .word_ready_o   (word_ready_o),
      .packet_o       (packet_o),
      .packet_len_o   (packet_len_o),
      .msgtype_o      (msgtype_o),
      .packet_valid_o (packet_valid_o),
      .packet_ready_i (packet_ready_i),
      .err_o          (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [127:0] pkt;
      logic [7:0]   len;
      logic [1:0]   mt;
   } exp_t;

   typedef struct {
      logic [31:0]  words [4];
      int           n;
      logic         legal;
      logic [127:0] exp_pkt;
      logic [7:0]   exp_len;
      logic [1:0]   exp_mt;
   } vec_t;

   int   total = 0;
   int   bad = 0;
   int   n_popped = 0;
   int   err_seen = 0;
   int   err_exp = 0;
   exp_t sb_q[$];
   vec_t vecs[8];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: compare every packet the consumer takes.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (packet_valid_o && packet_ready_i) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_pkt", 128'(packet_valid_o), 128'(0));
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("sb_packet", packet_o, e.pkt);
               check("sb_len", 128'(packet_len_o), 128'(e.len));
               check("sb_msgtype", 128'(msgtype_o), 128'(e.mt));
               n_popped++;
            end
         end
         if (err_o) err_seen++;
      end
   end

   // Drive point is 2 time units after the rising edge.
   task automatic send_word(input logic [31:0] w);
      int budget;
      budget = 100;
      word_i       = w;
      word_valid_i = 1'b1;
      #1;
      while (!word_ready_o && budget > 0) begin
         @(posedge clk_i);
         #3;
         budget--;
      end
      if (budget == 0) check("ready_timeout", 128'(word_ready_o), 128'(1));
      @(posedge clk_i);
      #2;
   endtask

   task automatic idle_cycles(input int n);
      word_valid_i = 1'b0;
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   task automatic push_vec(input int i);
      exp_t e;
      e.pkt = vecs[i].exp_pkt;
      e.len = vecs[i].exp_len;
      e.mt  = vecs[i].exp_mt;
      sb_q.push_back(e);
   endtask

   task automatic wait_drain();
      int budget;
      budget = 50;
      word_valid_i = 1'b0;
      while (sb_q.size() != 0 && budget > 0) begin
         @(posedge clk_i);
         budget--;
      end
      @(posedge clk_i);
      #2;
      check("sb_drain", 128'(sb_q.size()), 128'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;

      vecs[0] = '{'{32'hABCD_0129, 32'h0000_1234, 32'h0, 32'h0}, 2, 1'b1,
                  128'h0000_0000_0000_1234_ABCD_0129, 8'd48, 2'd2};
      vecs[1] = '{'{32'h0000_0079, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 4, 1'b1,
                  128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0079, 8'd128, 2'd0};
      vecs[2] = '{'{32'h0000_0099, 32'h0, 32'h0, 32'h0}, 1, 1'b1,
                  128'h0000_0099, 8'd32, 2'd1};
      vecs[3] = '{'{32'hFFFF_FF82, 32'h0, 32'h0, 32'h0}, 1, 1'b1,
                  128'h0000_0182, 8'd9, 2'd3};
      vecs[4] = '{'{32'h5555_5531, 32'hFFFF_FFFF, 32'h0, 32'h0}, 2, 1'b1,
                  128'h0000_0000_00FF_FFFF_5555_5531, 8'd56, 2'd2};
      vecs[5] = '{'{32'h0000_003C, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0}, 3, 1'b1,
                  128'h0000_0000_0000_0007_AAAA_AAAA_0000_003C, 8'd67, 2'd0};
      vecs[6] = '{'{32'h0000_007A, 32'h0, 32'h0, 32'h0}, 1, 1'b0, 128'h0, 8'd0, 2'd0};
      vecs[7] = '{'{32'hFFFF_FF81, 32'h0, 32'h0, 32'h0}, 1, 1'b0, 128'h0, 8'd0, 2'd0};

      rst_i          = 1'b1;
      word_i         = 32'h0;
      word_valid_i   = 1'b0;
      packet_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      check("rst_packet", packet_o, 128'h0);
      check("rst_len", 128'(packet_len_o), 128'h0);
      check("rst_msgtype", 128'(msgtype_o), 128'h0);
      check("rst_valid", 128'(packet_valid_o), 128'h0);
      check("rst_err", 128'(err_o), 128'h0);

      // 2-word packet: valid appears exactly one cycle after the last word.
      push_vec(0);
      send_word(vecs[0].words[0]);
      check("lat_mid_valid", 128'(packet_valid_o), 128'h0);
      send_word(vecs[0].words[1]);
      check("lat_valid", 128'(packet_valid_o), 128'h1);
      wait_drain();

      // Table of vectors streamed back to back.
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].legal) push_vec(i);
         else err_exp++;
         for (int w = 0; w < vecs[i].n; w++) send_word(vecs[i].words[w]);
      end
      wait_drain();

      // Back-to-back 1-word packets: one packet per cycle.
      base = n_popped;
      for (int i = 0; i < 6; i++) begin
         push_vec(2);
         send_word(32'h0000_0099);
         check("b2b_valid", 128'(packet_valid_o), 128'h1);
      end
      idle_cycles(1);
      check("b2b_count", 128'(n_popped - base), 128'd6);
      wait_drain();

      // Illegal header then legal one.
      err_exp++;
      send_word(32'h0000_007F);
      check("illegal_err_pulse", 128'(err_o), 128'h1);
      check("illegal_no_valid", 128'(packet_valid_o), 128'h0);
      push_vec(2);
      send_word(32'h0000_0099);
      check("illegal_err_once", 128'(err_o), 128'h0);
      wait_drain();

      // Backpressure: pending packet holds and blocks the next word.
      packet_ready_i = 1'b0;
      push_vec(2);
      send_word(32'h0000_0099);
      push_vec(3);
      word_i       = 32'hFFFF_FF82;
      word_valid_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_ready_low", 128'(word_ready_o), 128'h0);
         check("bp_packet_stable", packet_o, vecs[2].exp_pkt);
         @(posedge clk_i);
         #2;
      end
      packet_ready_i = 1'b1;
      #1;
      check("bp_release_ready", 128'(word_ready_o), 128'h1);
      @(posedge clk_i);
      #2;
      word_valid_i = 1'b0;
      check("bp_accept_same_cycle", packet_o, vecs[3].exp_pkt);
      wait_drain();

      // Reset mid-packet discards without error.
      send_word(32'hABCD_0129);
      word_valid_i = 1'b0;
      rst_i = 1'b1;
      @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      check("midrst_err", 128'(err_o), 128'h0);
      check("midrst_valid", 128'(packet_valid_o), 128'h0);
      check("midrst_packet", packet_o, 128'h0);
      push_vec(2);
      send_word(32'h0000_0099);
      wait_drain();

`ifdef TRDB_DESER_TIMEOUT_EN
      // Timeout after 8 idle cycles in COLLECT.
      err_exp++;
      send_word(32'hABCD_0129);
      idle_cycles(7);
      check("to_no_err_early", 128'(err_o), 128'h0);
      idle_cycles(1);
      check("to_err_pulse", 128'(err_o), 128'h1);
      check("to_no_valid", 128'(packet_valid_o), 128'h0);
      push_vec(2);
      send_word(32'h0000_0099);
      wait_drain();
`endif

      check("err_count", 128'(err_seen), 128'(err_exp));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
